// File: rtl/fetch_sequencer.sv
// Fetch-stage controller: owns the fetch PC, issues single-outstanding imem requests and
// presents instructions to IF/ID through an output slot backed by a one-entry skid buffer.
module fetch_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h01000000,
    parameter logic [31:0] NOP_INSTR    = 32'h00000013
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic [31:0] pc_out,
    output logic        misalign_err
);

    typedef enum logic [1:0] {BOOT, FETCH, HOLD, DRAIN} state_t;

    state_t      state, state_next;
    logic [31:0] pc_next, addr_next, if_pc_next, if_instr_next;
    logic        req_next, if_valid_next, misalign_next;
    logic        skid_valid, skid_valid_next;
    logic [31:0] skid_pc, skid_pc_next, skid_instr, skid_instr_next;

    logic        slot_free, consumed;
    logic [31:0] redirect_pc, pc_plus4;

    assign slot_free   = !if_valid || !stall;
    assign consumed    = if_valid && !stall;
    assign redirect_pc = {redirect_target[31:2], 2'b00};
    assign pc_plus4    = pc_out + 32'd4;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= BOOT;
            pc_out       <= RESET_VECTOR;
            imem_req     <= 1'b0;
            imem_addr    <= 32'h0;
            if_valid     <= 1'b0;
            if_pc        <= 32'h0;
            if_instr     <= NOP_INSTR;
            skid_valid   <= 1'b0;
            skid_pc      <= 32'h0;
            skid_instr   <= NOP_INSTR;
            misalign_err <= 1'b0;
        end else begin
            state        <= state_next;
            pc_out       <= pc_next;
            imem_req     <= req_next;
            imem_addr    <= addr_next;
            if_valid     <= if_valid_next;
            if_pc        <= if_pc_next;
            if_instr     <= if_instr_next;
            skid_valid   <= skid_valid_next;
            skid_pc      <= skid_pc_next;
            skid_instr   <= skid_instr_next;
            misalign_err <= misalign_next;
        end
    end

    always_comb begin
        state_next      = state;
        pc_next         = pc_out;
        req_next        = imem_req;
        addr_next       = imem_addr;
        if_valid_next   = if_valid;
        if_pc_next      = if_pc;
        if_instr_next   = if_instr;
        skid_valid_next = skid_valid;
        skid_pc_next    = skid_pc;
        skid_instr_next = skid_instr;
        misalign_next   = 1'b0;

        if (redirect_valid) begin
            pc_next         = redirect_pc;
            if_valid_next   = 1'b0;
            if_instr_next   = NOP_INSTR;
            skid_valid_next = 1'b0;
            misalign_next   = |redirect_target[1:0];
            // An unanswered request must stay on the bus with its old address until acked.
            if ((state == FETCH || state == DRAIN) && !imem_ack) begin
                state_next = DRAIN;
            end else begin
                state_next = FETCH;
                req_next   = 1'b1;
                addr_next  = redirect_pc;
            end
        end else begin
            if (consumed) begin
                if_valid_next = 1'b0;
                if_instr_next = NOP_INSTR;
            end
            case (state)
                BOOT: begin
                    state_next = FETCH;
                    req_next   = 1'b1;
                    addr_next  = pc_out;
                end
                FETCH: begin
                    if (imem_ack) begin
                        pc_next = pc_plus4;
                        if (slot_free) begin
                            if_valid_next = 1'b1;
                            if_pc_next    = imem_addr;
                            if_instr_next = imem_rdata;
                            addr_next     = pc_plus4;
                        end else begin
                            skid_valid_next = 1'b1;
                            skid_pc_next    = imem_addr;
                            skid_instr_next = imem_rdata;
                            state_next      = HOLD;
                            req_next        = 1'b0;
                        end
                    end
                end
                HOLD: begin
                    if (slot_free) begin
                        if_valid_next   = 1'b1;
                        if_pc_next      = skid_pc;
                        if_instr_next   = skid_instr;
                        skid_valid_next = 1'b0;
                        state_next      = FETCH;
                        req_next        = 1'b1;
                        addr_next       = pc_out;
                    end
                end
                DRAIN: begin
                    if (imem_ack) begin
                        state_next = FETCH;
                        req_next   = 1'b1;
                        addr_next  = pc_out;
                    end
                end
                default: state_next = BOOT;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed vector table, reset-during-HOLD sequence, then random
// traffic against a queue-based reference model of the fetch buffer.
module tb_fetch_sequencer;

    localparam logic [31:0] RV  = 32'h01000000;
    localparam logic [31:0] NOP = 32'h00000013;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = 32'h0;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        imem_req, if_valid, misalign_err;
    logic [31:0] imem_addr, if_pc, if_instr, pc_out;

    int checks = 0;
    int errors = 0;

    fetch_sequencer #(.RESET_VECTOR(RV), .NOP_INSTR(NOP)) dut (
        .clock(clock), .reset(reset), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
        .pc_out(pc_out), .misalign_err(misalign_err)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    // Reference model: buffered instructions as a queue (capacity two), one request tracker.
    logic [31:0] q_pc[$];
    logic [31:0] q_instr[$];
    logic [31:0] m_pc, m_addr;
    logic        m_out, m_discard, m_boot, m_mis;
    bit          model_on = 0;

    task automatic model_reset();
        q_pc.delete();
        q_instr.delete();
        m_pc = RV; m_addr = 32'h0; m_out = 0; m_discard = 0; m_boot = 1; m_mis = 0;
    endtask

    task automatic model_step(input logic st, input logic rd, input logic [31:0] tgt,
                              input logic ack, input logic [31:0] rdata);
        m_mis = rd && (tgt[1:0] != 2'b00);
        if (rd) begin
            q_pc.delete();
            q_instr.delete();
            m_pc = {tgt[31:2], 2'b00};
            m_boot = 0;
            if (m_out && !ack) m_discard = 1;
            else begin m_out = 1; m_addr = m_pc; m_discard = 0; end
        end else begin
            if (q_pc.size() > 0 && !st) begin
                void'(q_pc.pop_front());
                void'(q_instr.pop_front());
            end
            if (m_boot) begin
                m_boot = 0; m_out = 1; m_addr = m_pc;
            end else if (m_out && ack) begin
                if (m_discard) begin
                    m_discard = 0; m_addr = m_pc;
                end else begin
                    q_pc.push_back(m_addr);
                    q_instr.push_back(rdata);
                    m_pc = m_pc + 32'd4;
                    if (q_pc.size() >= 2) m_out = 0;
                    else m_addr = m_pc;
                end
            end else if (!m_out && q_pc.size() < 2) begin
                m_out = 1; m_addr = m_pc;
            end
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs (called just after a rising edge), clock it, land at edge+1.
    task automatic applyStimulus(input logic st, input logic rd, input logic [31:0] tgt,
                                 input logic ack);
        stall = st;
        redirect_valid = rd;
        redirect_target = tgt;
        imem_ack = ack;
        imem_rdata = ack ? mem_word(imem_addr) : $urandom;
        if (model_on) model_step(st, rd, tgt, ack, imem_rdata);
        @(posedge clock);
        #1;
    endtask

    task automatic check_model();
        checkOutput("m_if_valid", {31'h0, if_valid}, {31'h0, q_pc.size() > 0});
        if (q_pc.size() > 0) begin
            checkOutput("m_if_pc", if_pc, q_pc[0]);
            checkOutput("m_if_instr", if_instr, q_instr[0]);
        end else begin
            checkOutput("m_if_instr_nop", if_instr, NOP);
        end
        checkOutput("m_imem_req", {31'h0, imem_req}, {31'h0, m_out});
        if (m_out) checkOutput("m_imem_addr", imem_addr, m_addr);
        checkOutput("m_pc_out", pc_out, m_pc);
        checkOutput("m_misalign", {31'h0, misalign_err}, {31'h0, m_mis});
    endtask

    typedef struct {
        logic        st;
        logic        rd;
        logic [31:0] tgt;
        logic        ack;
        logic        e_valid;
        logic [31:0] e_pc;
        logic        e_req;
        logic [31:0] e_addr;
        logic [31:0] e_pcout;
        logic        e_mis;
    } vec_t;

    vec_t vecs[20];

    initial begin
        int mem_lat;
        bit mem_busy;
        logic st, rd, ack;
        logic [31:0] tgt;

        //            st rd  tgt           ack  valid pc            req addr          pc_out        mis
        vecs[0]  = '{0, 0, 32'h0,         0,   0, 32'h0,         1, RV,           RV,           0};
        vecs[1]  = '{0, 0, 32'h0,         1,   1, RV,            1, RV+4,         RV+4,         0};
        vecs[2]  = '{0, 0, 32'h0,         1,   1, RV+4,          1, RV+8,         RV+8,         0};
        vecs[3]  = '{0, 0, 32'h0,         1,   1, RV+8,          1, RV+12,        RV+12,        0};
        vecs[4]  = '{1, 0, 32'h0,         1,   1, RV+8,          0, 32'h0,        RV+16,        0};
        vecs[5]  = '{1, 0, 32'h0,         0,   1, RV+8,          0, 32'h0,        RV+16,        0};
        vecs[6]  = '{1, 0, 32'h0,         0,   1, RV+8,          0, 32'h0,        RV+16,        0};
        vecs[7]  = '{0, 0, 32'h0,         0,   1, RV+12,         1, RV+16,        RV+16,        0};
        vecs[8]  = '{0, 0, 32'h0,         1,   1, RV+16,         1, RV+20,        RV+20,        0};
        vecs[9]  = '{0, 1, 32'h01000100,  0,   0, 32'h0,         1, RV+20,        32'h01000100, 0};
        vecs[10] = '{0, 0, 32'h0,         0,   0, 32'h0,         1, RV+20,        32'h01000100, 0};
        vecs[11] = '{0, 0, 32'h0,         1,   0, 32'h0,         1, 32'h01000100, 32'h01000100, 0};
        vecs[12] = '{1, 0, 32'h0,         1,   1, 32'h01000100,  1, 32'h01000104, 32'h01000104, 0};
        vecs[13] = '{1, 1, 32'h01000202,  1,   0, 32'h0,         1, 32'h01000200, 32'h01000200, 1};
        vecs[14] = '{0, 0, 32'h0,         0,   0, 32'h0,         1, 32'h01000200, 32'h01000200, 0};
        vecs[15] = '{0, 1, 32'hFFFFFFFC,  1,   0, 32'h0,         1, 32'hFFFFFFFC, 32'hFFFFFFFC, 0};
        vecs[16] = '{0, 0, 32'h0,         1,   1, 32'hFFFFFFFC,  1, 32'h0,        32'h0,        0};
        vecs[17] = '{0, 0, 32'h0,         1,   1, 32'h0,         1, 32'h4,        32'h4,        0};
        vecs[18] = '{1, 0, 32'h0,         1,   1, 32'h0,         0, 32'h0,        32'h8,        0};
        vecs[19] = '{1, 0, 32'h0,         0,   1, 32'h0,         0, 32'h0,        32'h8,        0};

        repeat (3) @(posedge clock);
        #1;
        checkOutput("rst_if_valid", {31'h0, if_valid}, 32'h0);
        checkOutput("rst_imem_req", {31'h0, imem_req}, 32'h0);
        checkOutput("rst_imem_addr", imem_addr, 32'h0);
        checkOutput("rst_if_pc", if_pc, 32'h0);
        checkOutput("rst_if_instr", if_instr, NOP);
        checkOutput("rst_pc_out", pc_out, RV);
        checkOutput("rst_misalign", {31'h0, misalign_err}, 32'h0);
        reset = 1'b1;

        for (int i = 0; i < 20; i++) begin
            applyStimulus(vecs[i].st, vecs[i].rd, vecs[i].tgt, vecs[i].ack);
            checkOutput($sformatf("v%0d_if_valid", i), {31'h0, if_valid}, {31'h0, vecs[i].e_valid});
            checkOutput($sformatf("v%0d_if_instr", i), if_instr,
                        vecs[i].e_valid ? mem_word(vecs[i].e_pc) : NOP);
            if (vecs[i].e_valid) checkOutput($sformatf("v%0d_if_pc", i), if_pc, vecs[i].e_pc);
            checkOutput($sformatf("v%0d_imem_req", i), {31'h0, imem_req}, {31'h0, vecs[i].e_req});
            if (vecs[i].e_req) checkOutput($sformatf("v%0d_imem_addr", i), imem_addr, vecs[i].e_addr);
            checkOutput($sformatf("v%0d_pc_out", i), pc_out, vecs[i].e_pcout);
            checkOutput($sformatf("v%0d_misalign", i), {31'h0, misalign_err}, {31'h0, vecs[i].e_mis});
        end

        // Asynchronous reset while HOLD has both slot and skid full.
        #2 reset = 1'b0;
        #1;
        checkOutput("hold_rst_if_valid", {31'h0, if_valid}, 32'h0);
        checkOutput("hold_rst_imem_req", {31'h0, imem_req}, 32'h0);
        checkOutput("hold_rst_pc_out", pc_out, RV);
        checkOutput("hold_rst_if_instr", if_instr, NOP);
        stall = 1'b0;
        @(posedge clock);
        #1 reset = 1'b1;
        applyStimulus(0, 0, 32'h0, 0);
        checkOutput("resume_req", {31'h0, imem_req}, 32'h1);
        checkOutput("resume_addr", imem_addr, RV);
        applyStimulus(0, 0, 32'h0, 1);
        checkOutput("resume_if_valid", {31'h0, if_valid}, 32'h1);
        checkOutput("resume_if_pc", if_pc, RV);
        checkOutput("resume_if_instr", if_instr, mem_word(RV));

        // Random traffic against the reference model.
        reset = 1'b0;
        applyStimulus(0, 0, 32'h0, 0);
        reset = 1'b1;
        model_reset();
        model_on = 1;
        mem_busy = 0;
        mem_lat = 0;
        check_model();
        for (int c = 0; c < 3000; c++) begin
            st = ($urandom_range(0, 9) < 3);
            rd = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 19) == 0) tgt = 32'hFFFFFFF0 + {$urandom_range(0, 3), 2'b00};
            else tgt = RV + {$urandom_range(0, 255), 2'b00};
            if ($urandom_range(0, 5) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
            ack = 1'b0;
            if (imem_req) begin
                if (!mem_busy) begin
                    mem_busy = 1;
                    mem_lat = $urandom_range(0, 3);
                end
                if (mem_lat == 0) begin
                    ack = 1'b1;
                    mem_busy = 0;
                end else begin
                    mem_lat--;
                end
            end else begin
                mem_busy = 0;
            end
            applyStimulus(st, rd, tgt, ack);
            check_model();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
